can_cfg_arbiter: RTL and testbench

- Shares the single CAN-controller configuration bus (the cfg_* port of the CAN wrapper) between two requesters.
  - Requester 0: the host command parser.
  - Requester 1: the autonomous CAN frame/transmit scheduler.
- Runs one read or write at a time, with round-robin arbitration, an address-window check and an ack timeout, so a dead IP core can never hang a requester.
- Sits between the requesters and can_wrapper inside the USB-CDC debugger fabric.

---
 rtl/can_cfg_arbiter.sv | 170 +++++++++++++++++
 tb/tb_can_cfg_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_cfg_arbiter.sv
// can_cfg_arbiter
//   Shares the CAN-controller configuration bus between two requesters
//   (0: host command parser, 1: frame/transmit scheduler). It runs one
//   access at a time, arbitrates round-robin, rejects addresses outside the
//   CAN register window and aborts accesses that are never acknowledged.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   mX_req/addr/wdata/we           request payload, held until mX_done
//   mX_done/err/rdata              completion pulse, error flag, read data
//   cfg_addr/wdata/write/read      access toward can_wrapper (level strobes)
//   cfg_rdata/cfg_ack              response from can_wrapper
//   busy                           high whenever the arbiter is not idle
//   to_cnt                         saturating timeout event counter
module can_cfg_arbiter #(
   parameter logic [15:0] BASE_ADDR   = 16'h5000,
   parameter logic [15:0] WIN_SIZE    = 16'h0100,
   parameter int unsigned TIMEOUT_CYC = 64,
   parameter int unsigned TO_CNT_W    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                m0_req,
   input  logic [15:0]         m0_addr,
   input  logic [31:0]         m0_wdata,
   input  logic                m0_we,
   output logic                m0_done,
   output logic                m0_err,
   output logic [31:0]         m0_rdata,
   input  logic                m1_req,
   input  logic [15:0]         m1_addr,
   input  logic [31:0]         m1_wdata,
   input  logic                m1_we,
   output logic                m1_done,
   output logic                m1_err,
   output logic [31:0]         m1_rdata,
   output logic [15:0]         cfg_addr,
   output logic [31:0]         cfg_wdata,
   output logic                cfg_write,
   output logic                cfg_read,
   input  logic [31:0]         cfg_rdata,
   input  logic                cfg_ack,
   output logic                busy,
   output logic [TO_CNT_W-1:0] to_cnt
);

   localparam int unsigned WAIT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state, state_nxt;
   logic              owner;       // 0 = m0, 1 = m1
   logic              last_gnt;
   logic              we_r;
   logic              err_r;
   logic [31:0]       rd_cap;
   logic [WAIT_W-1:0] wait_cnt;

   logic              gnt;
   logic [15:0]       sel_addr;
   logic [31:0]       sel_wdata;
   logic              sel_we;
   logic [15:0]       offset;
   logic              in_win;
   logic              timeout_hit;
   logic              done_pending;

   always_comb begin
      if (m0_req && m1_req) gnt = ~last_gnt;
      else                  gnt = m1_req;
      sel_addr    = gnt ? m1_addr  : m0_addr;
      sel_wdata   = gnt ? m1_wdata : m0_wdata;
      sel_we      = gnt ? m1_we    : m0_we;
      // 16-bit wrap makes addresses below the base look huge, so one compare suffices
      offset      = sel_addr - BASE_ADDR;
      in_win      = offset < WIN_SIZE;
      timeout_hit = wait_cnt == WAIT_W'(TIMEOUT_CYC - 1);
      // done is registered one cycle after DONE; holding off grants while it
      // is visible gives the requester that cycle to present its next payload
      done_pending = m0_done | m1_done;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if ((m0_req || m1_req) && !done_pending)
                     state_nxt = in_win ? ACCESS : DONE;
         ACCESS:  if (cfg_ack || timeout_hit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner     <= 1'b0;
         last_gnt  <= 1'b1;
         we_r      <= 1'b0;
         err_r     <= 1'b0;
         rd_cap    <= '0;
         wait_cnt  <= '0;
         m0_done   <= 1'b0;
         m0_err    <= 1'b0;
         m0_rdata  <= '0;
         m1_done   <= 1'b0;
         m1_err    <= 1'b0;
         m1_rdata  <= '0;
         cfg_addr  <= '0;
         cfg_wdata <= '0;
         cfg_write <= 1'b0;
         cfg_read  <= 1'b0;
         busy      <= 1'b0;
         to_cnt    <= '0;
      end else begin
         m0_done <= 1'b0;
         m1_done <= 1'b0;
         busy    <= (state_nxt != IDLE);
         case (state)
            IDLE: begin
               if (state_nxt != IDLE) begin
                  owner     <= gnt;
                  last_gnt  <= gnt;
                  we_r      <= sel_we;
                  cfg_addr  <= sel_addr;
                  cfg_wdata <= sel_wdata;
                  wait_cnt  <= '0;
                  err_r     <= ~in_win;
                  if (in_win) begin
                     cfg_write <= sel_we;
                     cfg_read  <= ~sel_we;
                  end
               end
            end
            ACCESS: begin
               if (cfg_ack) begin
                  cfg_write <= 1'b0;
                  cfg_read  <= 1'b0;
                  rd_cap    <= cfg_rdata;
                  err_r     <= 1'b0;
               end else if (timeout_hit) begin
                  cfg_write <= 1'b0;
                  cfg_read  <= 1'b0;
                  err_r     <= 1'b1;
                  if (to_cnt != '1) to_cnt <= to_cnt + 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DONE: begin
               if (owner) begin
                  m1_done <= 1'b1;
                  m1_err  <= err_r;
                  if (!we_r && !err_r) m1_rdata <= rd_cap;
               end else begin
                  m0_done <= 1'b1;
                  m0_err  <= err_r;
                  if (!we_r && !err_r) m0_rdata <= rd_cap;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_can_cfg_arbiter.sv
// tb_can_cfg_arbiter
//   Self-checking bench for can_cfg_arbiter. A reference model tracks each
//   requester's visible read data and the timeout count from the access
//   rules (window, ack position, timeout limit); a behavioural CAN slave
//   acknowledges on a chosen strobe cycle.
module tb_can_cfg_arbiter;

   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [15:0] m0_addr = '0, m1_addr = '0;
   logic [31:0] m0_wdata = '0, m1_wdata = '0;
   logic        m0_done, m0_err, m1_done, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic [15:0] cfg_addr;
   logic [31:0] cfg_wdata;
   logic        cfg_write, cfg_read;
   logic [31:0] cfg_rdata = '0;
   logic        cfg_ack = 1'b0;
   logic        busy;
   logic [7:0]  to_cnt;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_rdata [2];
   int          exp_to;

   can_cfg_arbiter #(
      .BASE_ADDR(16'h5000), .WIN_SIZE(16'h0100),
      .TIMEOUT_CYC(TIMEOUT), .TO_CNT_W(8)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
      .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
      .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_write(cfg_write),
      .cfg_read(cfg_read), .cfg_rdata(cfg_rdata), .cfg_ack(cfg_ack),
      .busy(busy), .to_cnt(to_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic done_of(input int m);
      return (m == 0) ? m0_done : m1_done;
   endfunction
   function automatic logic err_of(input int m);
      return (m == 0) ? m0_err : m1_err;
   endfunction
   function automatic logic [31:0] rdata_of(input int m);
      return (m == 0) ? m0_rdata : m1_rdata;
   endfunction

   task automatic do_reset;
      rst_n = 1'b0; m0_req = 0; m1_req = 0; cfg_ack = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_rdata[0] = '0; exp_rdata[1] = '0; exp_to = 0;
   endtask

   task automatic set_req(input int m, input logic r, input logic [15:0] a,
                          input logic [31:0] d, input logic w);
      if (m == 0) begin m0_req = r; m0_addr = a; m0_wdata = d; m0_we = w; end
      else        begin m1_req = r; m1_addr = a; m1_wdata = d; m1_we = w; end
   endtask

   // One transaction from an idle arbiter. ack_k = strobe cycle carrying the
   // ack (0 = never acknowledged).
   task automatic run_txn(input int m, input logic [15:0] addr, input logic [31:0] wd,
                          input logic we, input int ack_k, input logic [31:0] rd);
      bit in_win, tmo, exp_err, kind_bad, addr_bad, other_bad;
      int exp_len, strobe_n, first_s, done_at, idx, o;
      logic [31:0] other_rd;
      logic        other_err;
      o        = 1 - m;
      in_win   = (int'(addr) >= 'h5000) && (int'(addr) < 'h5100);
      tmo      = in_win && (ack_k == 0 || ack_k > TIMEOUT);
      exp_err  = !in_win || tmo;
      exp_len  = !in_win ? 0 : (tmo ? TIMEOUT : ack_k);
      if (!we && !exp_err) exp_rdata[m] = rd;
      if (tmo && exp_to < 255) exp_to++;
      other_rd = rdata_of(o); other_err = err_of(o);
      kind_bad = 0; addr_bad = 0; other_bad = 0;
      strobe_n = 0; first_s = -1; done_at = -1; idx = 0;
      @(negedge clk);
      set_req(m, 1'b1, addr, wd, we);
      while (done_at < 0 && idx < 300) begin
         @(negedge clk);
         idx++;
         cfg_ack   = 1'b0;
         cfg_rdata = $urandom;
         if (cfg_write || cfg_read) begin
            if (first_s < 0) first_s = idx;
            strobe_n++;
            if (cfg_write !== we || cfg_read !== !we || busy !== 1'b1) kind_bad = 1;
            if (cfg_addr !== addr || (we && cfg_wdata !== wd)) addr_bad = 1;
            if (strobe_n == ack_k) begin cfg_ack = 1'b1; cfg_rdata = rd; end
         end
         if (done_of(o) !== 1'b0) other_bad = 1;
         if (done_of(m) === 1'b1) begin
            done_at = idx;
            checks++;
            if (err_of(m) !== exp_err) begin
               errors++;
               $display("FAIL err m%0d addr=%h: got %b want %b", m, addr, err_of(m), exp_err);
            end
            checks++;
            if (rdata_of(m) !== exp_rdata[m]) begin
               errors++;
               $display("FAIL rdata m%0d addr=%h: got %h want %h", m, addr, rdata_of(m), exp_rdata[m]);
            end
         end
      end
      set_req(m, 1'b0, addr, wd, we);
      cfg_ack = 1'b0;
      checks++;
      if (done_at != (in_win ? exp_len + 2 : 2)) begin
         errors++;
         $display("FAIL done_latency m%0d addr=%h: got %0d want %0d", m, addr, done_at,
                  in_win ? exp_len + 2 : 2);
      end
      checks++;
      if (strobe_n != exp_len || (in_win && first_s != 1)) begin
         errors++;
         $display("FAIL strobe_len m%0d addr=%h: got %0d (first %0d) want %0d (first 1)",
                  m, addr, strobe_n, first_s, exp_len);
      end
      checks++;
      if (kind_bad || addr_bad) begin
         errors++;
         $display("FAIL strobe_kind m%0d addr=%h: kind_bad=%0b addr_bad=%0b want 0 0",
                  m, addr, kind_bad, addr_bad);
      end
      checks++;
      if (other_bad || rdata_of(o) !== other_rd || err_of(o) !== other_err) begin
         errors++;
         $display("FAIL other_untouched m%0d: done_seen=%0b rdata %h want %h", o, other_bad,
                  rdata_of(o), other_rd);
      end
      checks++;
      if (int'(to_cnt) != exp_to) begin
         errors++;
         $display("FAIL to_cnt: got %0d want %0d", to_cnt, exp_to);
      end
   endtask

   task automatic test_reset;
      do_reset();
      @(negedge clk);
      checks++;
      if ({m0_done, m0_err, m1_done, m1_err, busy, cfg_write, cfg_read} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 0", {m0_done, m0_err, m1_done, m1_err, busy, cfg_write, cfg_read});
      end
      checks++;
      if ({m0_rdata, m1_rdata, cfg_addr, cfg_wdata, to_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_data: rdata %h %h addr %h wdata %h to %h want 0",
                  m0_rdata, m1_rdata, cfg_addr, cfg_wdata, to_cnt);
      end
   endtask

   task automatic test_basic;
      run_txn(0, 16'h5008, 32'h0000_00A5, 1'b1, 3, 32'h0);
      run_txn(1, 16'h50F0, 32'h0, 1'b0, 1, 32'hCAFE_F00D);
      run_txn(0, 16'h5004, 32'h0, 1'b0, 5, 32'h1234_5678);
   endtask

   task automatic test_arbitration;
      logic [31:0] data_q [4];
      int order_n, strobe_n, k, idx, who;
      do_reset();
      data_q[0] = 32'h1111_2222; data_q[1] = 32'h3333_4444;
      data_q[2] = $urandom;      data_q[3] = $urandom;
      @(negedge clk);
      set_req(0, 1'b1, 16'h5004, '0, 1'b0);
      set_req(1, 1'b1, 16'h5008, '0, 1'b0);
      order_n = 0; strobe_n = 0; idx = 0; k = $urandom_range(1, 5);
      while (order_n < 4 && idx < 400) begin
         @(negedge clk);
         idx++;
         cfg_ack = 1'b0; cfg_rdata = $urandom;
         if (cfg_read) begin
            strobe_n++;
            if (strobe_n == k) begin cfg_ack = 1'b1; cfg_rdata = data_q[order_n]; end
         end else strobe_n = 0;
         if (m0_done || m1_done) begin
            who = m1_done ? 1 : 0;
            checks++;
            if (who != order_n % 2 || (m0_done && m1_done)) begin
               errors++;
               $display("FAIL arb_order grant %0d: got m%0d (both=%0b) want m%0d",
                        order_n, who, m0_done && m1_done, order_n % 2);
            end
            exp_rdata[order_n % 2] = data_q[order_n];
            checks++;
            if (rdata_of(who) !== data_q[order_n]) begin
               errors++;
               $display("FAIL arb_rdata grant %0d: got %h want %h", order_n, rdata_of(who), data_q[order_n]);
            end
            order_n++;
            k = $urandom_range(1, 5);
            if (order_n == 4) begin m0_req = 1'b0; m1_req = 1'b0; end
         end
      end
      cfg_ack = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
      checks++;
      if (order_n != 4) begin
         errors++;
         $display("FAIL arb_progress: got %0d completions want 4", order_n);
      end
   endtask

   task automatic test_timeout;
      run_txn(1, 16'h5010, 32'h0, 1'b0, 0, 32'h0);
   endtask

   task automatic test_window;
      run_txn(0, 16'h4FFC, 32'h5A5A_5A5A, 1'b1, 1, 32'h0);
      run_txn(0, 16'h5100, 32'h5A5A_5A5A, 1'b1, 1, 32'h0);
      run_txn(1, 16'h0010, 32'h0, 1'b0, 1, 32'hDEAD_BEEF);
      run_txn(1, 16'h5000, 32'h0, 1'b0, 2, 32'h0BAD_CAFE);
      run_txn(0, 16'h50FF, 32'h0, 1'b0, 2, 32'h7777_8888);
   endtask

   task automatic test_ack_at_limit;
      run_txn(0, 16'h5040, 32'h0, 1'b0, TIMEOUT, 32'hA1B2_C3D4);
   endtask

   task automatic test_reset_mid;
      int idx;
      @(negedge clk);
      set_req(0, 1'b1, 16'h5020, '0, 1'b0);
      idx = 0;
      while (!cfg_read && idx < 20) begin @(negedge clk); idx++; end
      repeat (2) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (cfg_read !== 1'b0 || cfg_write !== 1'b0 || busy !== 1'b0 || idx >= 20) begin
         errors++;
         $display("FAIL reset_mid_strobe: read=%b write=%b busy=%b want 0 0 0", cfg_read, cfg_write, busy);
      end
      m0_req = 1'b0;
      exp_rdata[0] = '0; exp_rdata[1] = '0; exp_to = 0;
      @(negedge clk);
      rst_n = 1'b1;
      idx = 0;
      repeat (5) begin
         @(negedge clk);
         if (m0_done || m1_done || cfg_read || cfg_write) idx++;
      end
      checks++;
      if (idx != 0) begin
         errors++;
         $display("FAIL reset_mid_quiet: got %0d active cycles want 0", idx);
      end
      run_txn(1, 16'h5030, 32'h0, 1'b0, 2, 32'h2468_ACE0);
   endtask

   task automatic test_random;
      logic [15:0] a;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0: a = 16'h5000 + 16'($urandom_range(0, 255));
            1: a = 16'($urandom_range(0, 16'h4FFF));
            2: a = 16'($urandom_range(16'h5100, 16'hFFFF));
            default: a = ($urandom_range(0, 1) != 0) ? 16'h5000 : 16'h50FF;
         endcase
         run_txn($urandom_range(0, 1), a, $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 70), $urandom);
      end
   endtask

   task automatic test_saturation;
      int guard;
      guard = 0;
      while (exp_to < 255 && guard < 300) begin
         run_txn($urandom_range(0, 1), 16'h5000 + 16'($urandom_range(0, 255)),
                 $urandom, 1'($urandom_range(0, 1)), 0, 32'h0);
         guard++;
      end
      run_txn(0, 16'h5080, 32'h0, 1'b0, 0, 32'h0);
      checks++;
      if (to_cnt !== 8'hFF) begin
         errors++;
         $display("FAIL to_cnt_saturate: got %h want ff", to_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_arbitration();
      test_timeout();
      test_window();
      test_ack_at_limit();
      test_reset_mid();
      test_random();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
